// File: rtl/alu_result_checker_if.sv
// Sample bus between the ALU stimulus/response side and the result checker.
// Carries the operands and op code applied to the ALU, plus the ALU's outputs.
//   master : stimulus side, drives every signal
//   slave  : checker side, observes every signal
interface alu_result_checker_if #(
   parameter int unsigned WIDTH = 32
) ();
   logic             sample_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       alu_ctr;
   logic [WIDTH-1:0] r;
   logic             c_out;
   logic             z;

   modport master (
      output sample_valid, a, b, alu_ctr, r, c_out, z
   );

   modport slave (
      input sample_valid, a, b, alu_ctr, r, c_out, z
   );
endinterface

// File: rtl/alu_result_checker.sv
// Response checker for the 32-bit ALU. Recomputes each sample with a golden
// model, compares against the ALU outputs two edges later, and keeps
// saturating pass/fail/skip counters plus a capture of the first mismatch.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start, end_test   run control pulses (IDLE/DONE -> RUN, RUN -> DRAIN)
//   smp               sample bus (slave side): valid, a, b, alu_ctr, r, c_out, z
//   busy, done        RUN/DRAIN and DONE indicators
//   error             sticky mismatch flag since the last start
//   pass/fail/skip_count  event counters
//   first_fail_*      sample and expected result of the first mismatch
module alu_result_checker #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 end_test,
   alu_result_checker_if.slave  smp,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [CNT_WIDTH-1:0] pass_count,
   output logic [CNT_WIDTH-1:0] fail_count,
   output logic [CNT_WIDTH-1:0] skip_count,
   output logic [WIDTH-1:0]     first_fail_a,
   output logic [WIDTH-1:0]     first_fail_b,
   output logic [2:0]           first_fail_ctr,
   output logic [WIDTH-1:0]     first_fail_r,
   output logic [WIDTH-1:0]     first_fail_exp
);
   localparam int unsigned SUM_W = WIDTH + 1;
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e               state_q, state_d;
   logic                 busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic [CNT_WIDTH-1:0] pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
   logic [WIDTH-1:0]     ff_a_q, ff_a_d, ff_b_q, ff_b_d;
   logic [WIDTH-1:0]     ff_r_q, ff_r_d, ff_exp_q, ff_exp_d;
   logic [2:0]           ff_ctr_q, ff_ctr_d;

   // Stage 1: captured sample plus its golden result
   logic                 s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_r_q, s1_r_d;
   logic [WIDTH-1:0]     s1_exp_r_q, s1_exp_r_d;
   logic [2:0]           s1_ctr_q, s1_ctr_d;
   logic                 s1_c_q, s1_c_d, s1_z_q, s1_z_d;
   logic                 s1_exp_c_q, s1_exp_c_d, s1_exp_z_q, s1_exp_z_d;
   logic                 s1_sup_q, s1_sup_d, s1_arith_q, s1_arith_d;

   logic [SUM_W-1:0]     sum_c;
   logic [WIDTH-1:0]     exp_r_c;
   logic                 exp_c_c, sup_c, arith_c;
   logic                 enter_run_c, mismatch_c;

   // Golden model; SUB is a + ~b + 1 so carry-out means a >= b unsigned
   always_comb begin
      sum_c   = '0;
      exp_r_c = '0;
      exp_c_c = 1'b0;
      sup_c   = 1'b1;
      arith_c = 1'b0;
      case (smp.alu_ctr)
         OP_AND: exp_r_c = smp.a & smp.b;
         OP_OR:  exp_r_c = smp.a | smp.b;
         OP_XOR: exp_r_c = smp.a ^ smp.b;
         OP_ADD: begin
            sum_c   = {1'b0, smp.a} + {1'b0, smp.b};
            exp_r_c = sum_c[WIDTH-1:0];
            exp_c_c = sum_c[WIDTH];
            arith_c = 1'b1;
         end
         OP_SUB: begin
            sum_c   = {1'b0, smp.a} + {1'b0, ~smp.b} + SUM_W'(1);
            exp_r_c = sum_c[WIDTH-1:0];
            exp_c_c = sum_c[WIDTH];
            arith_c = 1'b1;
         end
         default: sup_c = 1'b0;
      endcase
   end

   // Carry is only meaningful for arithmetic ops
   assign mismatch_c = (s1_r_q != s1_exp_r_q) || (s1_z_q != s1_exp_z_q) ||
                       (s1_arith_q && (s1_c_q != s1_exp_c_q));

   assign enter_run_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   // Next-state, stage-1 load and scoring
   always_comb begin
      state_d    = state_q;
      pass_d     = pass_q;
      fail_d     = fail_q;
      skip_d     = skip_q;
      error_d    = error_q;
      ff_a_d     = ff_a_q;
      ff_b_d     = ff_b_q;
      ff_ctr_d   = ff_ctr_q;
      ff_r_d     = ff_r_q;
      ff_exp_d   = ff_exp_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_ctr_d   = s1_ctr_q;
      s1_r_d     = s1_r_q;
      s1_c_d     = s1_c_q;
      s1_z_d     = s1_z_q;
      s1_exp_r_d = s1_exp_r_q;
      s1_exp_c_d = s1_exp_c_q;
      s1_exp_z_d = s1_exp_z_q;
      s1_sup_d   = s1_sup_q;
      s1_arith_d = s1_arith_q;

      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (end_test) state_d = S_DRAIN;
         S_DRAIN: state_d = S_DONE;
         S_DONE:  if (start) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);

      // The end_test cycle no longer accepts samples
      s1_valid_d = (state_q == S_RUN) && smp.sample_valid && !end_test;
      if (s1_valid_d) begin
         s1_a_d     = smp.a;
         s1_b_d     = smp.b;
         s1_ctr_d   = smp.alu_ctr;
         s1_r_d     = smp.r;
         s1_c_d     = smp.c_out;
         s1_z_d     = smp.z;
         s1_exp_r_d = exp_r_c;
         s1_exp_c_d = exp_c_c;
         s1_exp_z_d = (exp_r_c == '0);
         s1_sup_d   = sup_c;
         s1_arith_d = arith_c;
      end

      // Stage 1 is always empty in IDLE/DONE, so clearing never drops a sample
      if (enter_run_c) begin
         pass_d   = '0;
         fail_d   = '0;
         skip_d   = '0;
         error_d  = 1'b0;
         ff_a_d   = '0;
         ff_b_d   = '0;
         ff_ctr_d = '0;
         ff_r_d   = '0;
         ff_exp_d = '0;
      end else if (s1_valid_q) begin
         if (!s1_sup_q) begin
            if (skip_q != '1) skip_d = skip_q + CNT_WIDTH'(1);
         end else if (mismatch_c) begin
            if (fail_q != '1) fail_d = fail_q + CNT_WIDTH'(1);
            if (!error_q) begin
               ff_a_d   = s1_a_q;
               ff_b_d   = s1_b_q;
               ff_ctr_d = s1_ctr_q;
               ff_r_d   = s1_r_q;
               ff_exp_d = s1_exp_r_q;
            end
            error_d = 1'b1;
         end else begin
            if (pass_q != '1) pass_d = pass_q + CNT_WIDTH'(1);
         end
      end
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         pass_q     <= '0;
         fail_q     <= '0;
         skip_q     <= '0;
         ff_a_q     <= '0;
         ff_b_q     <= '0;
         ff_ctr_q   <= '0;
         ff_r_q     <= '0;
         ff_exp_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_ctr_q   <= '0;
         s1_r_q     <= '0;
         s1_c_q     <= 1'b0;
         s1_z_q     <= 1'b0;
         s1_exp_r_q <= '0;
         s1_exp_c_q <= 1'b0;
         s1_exp_z_q <= 1'b0;
         s1_sup_q   <= 1'b0;
         s1_arith_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         skip_q     <= skip_d;
         ff_a_q     <= ff_a_d;
         ff_b_q     <= ff_b_d;
         ff_ctr_q   <= ff_ctr_d;
         ff_r_q     <= ff_r_d;
         ff_exp_q   <= ff_exp_d;
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_ctr_q   <= s1_ctr_d;
         s1_r_q     <= s1_r_d;
         s1_c_q     <= s1_c_d;
         s1_z_q     <= s1_z_d;
         s1_exp_r_q <= s1_exp_r_d;
         s1_exp_c_q <= s1_exp_c_d;
         s1_exp_z_q <= s1_exp_z_d;
         s1_sup_q   <= s1_sup_d;
         s1_arith_q <= s1_arith_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign pass_count     = pass_q;
   assign fail_count     = fail_q;
   assign skip_count     = skip_q;
   assign first_fail_a   = ff_a_q;
   assign first_fail_b   = ff_b_q;
   assign first_fail_ctr = ff_ctr_q;
   assign first_fail_r   = ff_r_q;
   assign first_fail_exp = ff_exp_q;
endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
Synthesizable response checker that sits on the receive side of the ALU stimulus/response interface. Each cycle, the stimulus side presents operands and an op code together with the alu_32bit outputs r/c_out/z. This block recomputes the expected result with a golden model, compares it against the actual outputs, and keeps pass/fail/skip counters. It also captures the first mismatch, so simulation benches and FPGA bring-up get a single pass/fail verdict.

Parameters:
WIDTH, 32, operand/result width
CNT_WIDTH, 16, width of each event counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  pulse: clear counters/capture, enter RUN
end_test  input  1  pulse: stop accepting samples, drain, enter DONE
sample_valid  input  1  sample present this cycle
a  input  WIDTH  operand A applied to ALU
b  input  WIDTH  operand B applied to ALU
alu_ctr  input  3  op code applied to ALU
r  input  WIDTH  ALU result
c_out  input  1  ALU carry out
z  input  1  ALU zero flag
busy  output  1  high in RUN or DRAIN
done  output  1  high in DONE
error  output  1  sticky: at least one mismatch since start
pass_count  output  CNT_WIDTH  compared samples that matched
fail_count  output  CNT_WIDTH  compared samples that mismatched
skip_count  output  CNT_WIDTH  samples with unsupported alu_ctr
first_fail_a  output  WIDTH  a of first mismatching sample
first_fail_b  output  WIDTH  b of first mismatching sample
first_fail_ctr  output  3  alu_ctr of first mismatch
first_fail_r  output  WIDTH  actual r of first mismatch
first_fail_exp  output  WIDTH  expected r of first mismatch

Behaviour:
- Golden model:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 111 XOR.
  - ADD: exp_r = (a+b) mod 2^WIDTH; exp_c = carry out of bit WIDTH-1.
  - SUB: computed as a + ~b + 1; exp_c = carry out, so exp_c = 1 iff a >= b unsigned.
  - exp_z = (exp_r == 0) for all supported ops.
  - Compare r and z for every supported op. Compare c_out only for ADD/SUB; it is don't-care for logic ops.
  - alu_ctr 011/100/101 are unsupported: no compare, counts as skip.
- FSM states: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
  - IDLE: start -> RUN.
  - RUN: end_test -> DRAIN.
  - DRAIN: unconditional -> DONE after 1 cycle.
  - DONE: start -> RUN.
  - start in RUN or DRAIN is ignored. end_test outside RUN is ignored.
  - Entering RUN clears all counters, error, and the first_fail_* fields in the same edge.
- Pipeline: 2 stages.
  - Edge N: in RUN with sample_valid=1, register the inputs and the golden results into stage 1, with a stage-1 valid bit.
  - Edge N+1: compare stage 1 and update counters/error/capture. Outputs reflect the sample 2 edges after it was presented.
  - sample_valid outside RUN is ignored, including on the end_test cycle and in DRAIN.
  - A sample already in stage 1 when end_test arrives is still scored during DRAIN, so counts are final when done rises.
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap. error still sets on a mismatch even if fail_count is saturated.
- First-fail capture: loaded only on the mismatch that first sets error. Later mismatches do not overwrite it.
- Reset: state IDLE; busy=0, done=0, error=0; all counts 0; all first_fail_* 0; stage-1 valid=0. Reset mid-RUN discards the in-flight sample.
- Back-to-back samples every cycle are supported. Throughput is 1 sample/cycle.

Test Plan:
1. reset, start, then samples (a=10,b=30): ctr 000 r=10; ctr 001 r=30; ctr 010 r=40 c_out=0; then end_test -> done=1 two edges later, pass_count=3, fail_count=0, error=0.
2. SUB checks:
   - a=10,b=30, ctr 110, r=0xFFFFFFEC, c_out=0, z=0 -> pass.
   - a=100,b=99, r=1, c_out=1 -> pass.
   - a=100,b=99, r=1, c_out=0 -> fail_count=1, error=1.
3. XOR a=20,b=20, ctr 111, r=0, z=1 -> pass. Same sample with z=0 -> fail. AND a=0,b=20 with c_out=1 -> pass (carry masked).
4. Two mismatches in a row: ADD a=0,b=20, r=21, then XOR a=10,b=30, r=0 -> fail_count=2. first_fail_a=0, first_fail_b=20, first_fail_ctr=010, first_fail_r=21, first_fail_exp=20.
5. Skips and ignored inputs: ctr 011 and ctr 101 samples -> skip_count=2, pass/fail unchanged. sample_valid in IDLE -> no count change. start pulse in DONE -> all counters 0, error=0.
6. Other edge cases:
   - Reset asserted one cycle after a sample is accepted -> no counter ever increments.
   - Force pass_count to 0xFFFF with CNT_WIDTH=16, then one more passing sample -> stays 0xFFFF.
